// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM plus an MMIO block holding a cycle counter,
// an output FIFO drained over valid/ready, and a sticky halt flag.
module dmem_responder #(
    parameter int    RAM_WORDS  = 512,
    parameter int    FIFO_DEPTH = 8,
    parameter string INIT_FILE  = ""
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [9:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        out_valid,
    output logic [31:0] out_data,
    input  logic        out_ready,
    output logic        halted
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   ram  [RAM_WORDS];
    logic [31:0]   fifo [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [31:0]   cycle;
    logic          overflow;

    logic          ram_hit;
    logic [AW-1:0] ram_idx;
    logic          wr_cycle;
    logic          wr_fifo;
    logic          wr_status;
    logic          wr_halt;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [31:0]   status;
    logic          unused_read;

    assign unused_read = MemRead;

    assign ram_hit = !address[9]
                     && ({1'b0, address[8:0]} < 10'(RAM_WORDS));
    assign ram_idx = address[AW-1:0];

    assign wr_cycle  = MemWrite && address[9] && (address[2:0] == 3'd0);
    assign wr_fifo   = MemWrite && address[9] && (address[2:0] == 3'd1);
    assign wr_status = MemWrite && address[9] && (address[2:0] == 3'd2);
    assign wr_halt   = MemWrite && address[9] && (address[2:0] == 3'd3);

    assign empty = (count == '0);
    assign full  = (count == CW'(FIFO_DEPTH));
    assign pop   = !empty && out_ready;
    assign push  = wr_fifo && (!full || pop);

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : fifo[rd_ptr];

    assign status = {25'b0, overflow, empty, full, 4'(count)};

    always_comb begin
        read_data = '0;
        if (!address[9]) begin
            if (ram_hit) read_data = ram[ram_idx];
        end else begin
            unique case (address[2:0])
                3'd0:    read_data = cycle;
                3'd2:    read_data = status;
                3'd3:    read_data = {31'b0, halted};
                default: read_data = '0;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (MemWrite && ram_hit) ram[ram_idx] <= write_data;
    end

    always_ff @(posedge CLK) begin
        if (push) fifo[wr_ptr] <= write_data;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            cycle    <= '0;
            halted   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
            if (wr_fifo && full && !pop) overflow <= 1'b1;
            else if (wr_status)          overflow <= 1'b0;
            if (wr_cycle)     cycle <= write_data;
            else if (!halted) cycle <= cycle + 32'd1;
            if (wr_halt && write_data[0]) halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus random traffic, all
// checked against a queue/array reference model of the memory map.
module tb_dmem_responder;

    localparam int RW = 256;
    localparam int FD = 8;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b1;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [9:0]  address = '0;
    logic [31:0] write_data = '0;
    logic        out_ready = 1'b0;
    logic [31:0] read_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        halted;

    dmem_responder #(
        .RAM_WORDS (RW),
        .FIFO_DEPTH(FD),
        .INIT_FILE ("")
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .address   (address),
        .write_data(write_data),
        .read_data (read_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .halted    (halted)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int n_cyc    = 0;

    // reference model
    logic [31:0] m_ram [RW];
    bit          m_ok  [RW];
    logic [31:0] m_q   [$];
    bit          m_ovf;
    bit          m_halt;
    logic [31:0] m_cyc;

    logic [31:0] rd_s;
    logic        ov_s;
    logic [31:0] od_s;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [9:0] a,
                                           output bit known);
        known = 1'b1;
        if (!a[9]) begin
            if (int'(a[8:0]) >= RW) return 32'h0;
            known = m_ok[int'(a[7:0])];
            return m_ram[int'(a[7:0])];
        end
        case (a[2:0])
            3'd0: return m_cyc;
            3'd2: return {25'b0, m_ovf, m_q.size() == 0,
                          m_q.size() == FD, 4'(m_q.size() % 16)};
            3'd3: return {31'b0, m_halt};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ovf  = 1'b0;
        m_halt = 1'b0;
        m_cyc  = '0;
    endtask

    // One bus cycle: drive at negedge, check pre-edge outputs, advance model.
    task automatic bus(input bit we, input logic [9:0] a,
                       input logic [31:0] wd, input bit rdy);
        bit          known;
        logic [31:0] e;
        bit          mm;
        MemWrite   = we;
        MemRead    = !we;
        address    = a;
        write_data = wd;
        out_ready  = rdy;
        #1;
        rd_s = read_data;
        ov_s = out_valid;
        od_s = out_data;
        e = m_read(a, known);
        if (known) check("read_data", read_data, e);
        check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
        check("out_data", out_data, (m_q.size() != 0) ? m_q[0] : 32'h0);
        check("halted", 32'(halted), 32'(m_halt));
        @(posedge CLK);
        n_cyc++;
        mm = a[9];
        if (rdy && m_q.size() != 0) void'(m_q.pop_front());
        if (we && !mm && int'(a[8:0]) < RW) begin
            m_ram[int'(a[7:0])] = wd;
            m_ok[int'(a[7:0])]  = 1'b1;
        end
        if (we && mm && a[2:0] == 3'd1) begin
            if (m_q.size() < FD) m_q.push_back(wd);
            else m_ovf = 1'b1;
        end
        if (we && mm && a[2:0] == 3'd2) m_ovf = 1'b0;
        if (we && mm && a[2:0] == 3'd0) m_cyc = wd;
        else if (!m_halt) m_cyc = m_cyc + 32'd1;
        if (we && mm && a[2:0] == 3'd3 && wd[0]) m_halt = 1'b1;
        @(negedge CLK);
    endtask

    task automatic hard_reset();
        MemWrite  = 1'b0;
        address   = 10'h200;
        out_ready = 1'b0;
        RSTn      = 1'b0;
        #1;
        model_reset();
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", out_data, 32'h0);
        check("rst_cycle", read_data, 32'h0);
        @(negedge CLK);
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    task automatic drain(input logic [31:0] exp [$], input string tag);
        int got = 0;
        for (int k = 0; k < 40; k++) begin
            bus(1'b0, 10'h206, 32'h0, 1'b1);
            if (!ov_s) break;
            if (got < exp.size()) check(tag, od_s, exp[got]);
            got++;
        end
        check({tag, "_count"}, 32'(got), 32'(exp.size()));
    endtask

    initial begin
        #100000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] exp [$];
        logic [31:0] arr [8];
        logic [31:0] frz;
        int          t0;
        for (int i = 0; i < RW; i++) m_ok[i] = 1'b0;
        model_reset();
        #2;
        @(negedge CLK);

        // RAM store/load and out-of-range decode
        hard_reset();
        bus(1'b1, 10'h005, 32'hDEADBEEF, 1'b0);
        bus(1'b0, 10'h005, 32'h0, 1'b0);
        check("ram_load", rd_s, 32'hDEADBEEF);
        bus(1'b1, 10'h005, 32'h12345678, 1'b0);
        check("ram_old_on_write", rd_s, 32'hDEADBEEF);
        bus(1'b0, 10'h005, 32'h0, 1'b0);
        check("ram_new", rd_s, 32'h12345678);
        bus(1'b1, 10'h1FF, 32'hFFFF0000, 1'b0);
        bus(1'b0, 10'h1FF, 32'h0, 1'b0);
        check("ram_out_of_range", rd_s, 32'h0);
        bus(1'b0, 10'h205, 32'h0, 1'b0);
        check("mmio_hole", rd_s, 32'h0);

        // cycle counter and wrap
        hard_reset();
        for (int i = 0; i < 10; i++) bus(1'b0, 10'h206, 32'h0, 1'b0);
        bus(1'b0, 10'h200, 32'h0, 1'b0);
        check("cycle_after_10", rd_s, 32'd10);
        bus(1'b1, 10'h200, 32'hFFFFFFFE, 1'b0);
        bus(1'b0, 10'h206, 32'h0, 1'b0);
        bus(1'b0, 10'h206, 32'h0, 1'b0);
        bus(1'b0, 10'h200, 32'h0, 1'b0);
        check("cycle_wrap", rd_s, 32'h0);

        // fill, overflow, drain, clear
        for (int i = 1; i <= 8; i++) bus(1'b1, 10'h201, 32'(i), 1'b0);
        bus(1'b0, 10'h202, 32'h0, 1'b0);
        check("status_full", rd_s, 32'h18);
        bus(1'b1, 10'h201, 32'd9, 1'b0);
        bus(1'b0, 10'h202, 32'h0, 1'b0);
        check("status_ovf", rd_s, 32'h58);
        bus(1'b0, 10'h201, 32'h0, 1'b0);
        check("fifo_data_read", rd_s, 32'h0);
        exp.delete();
        for (int i = 1; i <= 8; i++) exp.push_back(32'(i));
        drain(exp, "drain_seq");
        bus(1'b0, 10'h202, 32'h0, 1'b0);
        check("status_empty_ovf", rd_s, 32'h60);
        bus(1'b1, 10'h202, 32'h0, 1'b0);
        bus(1'b0, 10'h202, 32'h0, 1'b0);
        check("status_cleared", rd_s, 32'h20);

        // push and pop together while full
        for (int i = 1; i <= 8; i++) bus(1'b1, 10'h201, 32'(10 + i), 1'b0);
        bus(1'b1, 10'h201, 32'hA5, 1'b1);
        bus(1'b0, 10'h202, 32'h0, 1'b0);
        check("status_pushpop", rd_s, 32'h18);
        exp.delete();
        for (int i = 2; i <= 8; i++) exp.push_back(32'(10 + i));
        exp.push_back(32'hA5);
        drain(exp, "pushpop_seq");

        // random traffic
        hard_reset();
        for (int n = 0; n < 3000; n++) begin
            int          r;
            bit          we;
            logic [9:0]  a;
            logic [31:0] wd;
            r  = $urandom_range(0, 99);
            we = ($urandom_range(0, 1) == 1);
            wd = $urandom;
            if (r < 30)      a = 10'($urandom_range(0, 15));
            else if (r < 38) a = 10'h100 + 10'($urandom_range(0, 255));
            else if (r < 65) a = 10'h201;
            else             a = 10'h200 + 10'($urandom_range(0, 7));
            if (a == 10'h203 && $urandom_range(0, 19) != 0) wd[0] = 1'b0;
            bus(we, a, wd, $urandom_range(0, 2) == 0);
        end

        // halt freezes the counter, reset clears everything
        hard_reset();
        for (int i = 0; i < 3; i++) bus(1'b1, 10'h201, 32'(100 + i), 1'b0);
        bus(1'b1, 10'h203, 32'h1, 1'b0);
        frz = m_cyc;
        for (int i = 0; i < 5; i++) begin
            bus(1'b0, 10'h200, 32'h0, 1'b0);
            check("cycle_frozen", rd_s, frz);
        end
        bus(1'b1, 10'h203, 32'h0, 1'b0);
        bus(1'b0, 10'h203, 32'h0, 1'b0);
        check("halt_sticky", rd_s, 32'h1);
        bus(1'b1, 10'h200, 32'h77, 1'b0);
        bus(1'b0, 10'h200, 32'h0, 1'b0);
        check("cycle_load_halted", rd_s, 32'h77);
        hard_reset();
        bus(1'b0, 10'h202, 32'h0, 1'b0);
        check("status_after_rst", rd_s, 32'h20);

        // sort program: store, load, sort, store, stream out, halt
        t0 = n_cyc;
        exp.delete();
        for (int i = 0; i < 8; i++) begin
            arr[i] = $urandom_range(0, 999);
            exp.push_back(arr[i]);
            bus(1'b1, 10'h010 + 10'(i), arr[i], 1'b0);
        end
        exp.sort();
        for (int i = 0; i < 8; i++) begin
            bus(1'b0, 10'h010 + 10'(i), 32'h0, 1'b0);
            arr[i] = rd_s;
        end
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7 - i; j++)
                if (arr[j] > arr[j+1]) begin
                    logic [31:0] t;
                    t = arr[j]; arr[j] = arr[j+1]; arr[j+1] = t;
                end
        for (int i = 0; i < 8; i++) bus(1'b1, 10'h010 + 10'(i), arr[i], 1'b0);
        for (int i = 0; i < 8; i++) begin
            bus(1'b0, 10'h010 + 10'(i), 32'h0, 1'b0);
            bus(1'b1, 10'h201, rd_s, 1'b0);
        end
        bus(1'b1, 10'h203, 32'h1, 1'b0);
        drain(exp, "sorted_seq");
        check("halt_within_1000",
              32'(halted == 1'b1 && (n_cyc - t0) < 1000), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
